// File: rtl/prod_acc_pkg.sv
// Shared definitions for the product accumulator: state encoding,
// default accumulator width and adder stage count helper.
package prod_acc_pkg;

    localparam int ACC_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_t;

    function automatic int num_stages(input int width);
        return (width + 3) / 4;
    endfunction

endpackage

// File: rtl/prod_acc_cla4.sv
// 4-bit carry-lookahead adder slice; chained by ripple carry in prod_acc.
module prod_acc_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Lookahead carries expanded from generate/propagate terms
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/prod_acc.sv
// Accumulates a run of 1..16 unsigned 8-bit products into an ACC_W-bit
// modulo sum with a sticky overflow flag and a ready/valid result handshake.
module prod_acc
    import prod_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Len,
    input  logic             P_valid,
    input  logic [7:0]       P,
    input  logic             Res_ready,
    output logic             Busy,
    output logic [ACC_W-1:0] Sum,
    output logic             Sum_valid,
    output logic             Overflow
);

    localparam int NST = num_stages(ACC_W);
    localparam int PW  = NST * 4;

    state_t           state, state_nx;
    logic [ACC_W-1:0] acc, acc_nx;
    logic [4:0]       cnt, cnt_nx;
    logic             ovf_nx;
    logic [ACC_W-1:0] sum_nx;
    logic             sv_nx;

    logic [PW-1:0]    add_a, add_b, add_s;
    logic [NST:0]     carry;
    logic [PW:0]      add_full;
    logic             add_cy;

    // Operands are zero-padded up to a whole number of 4-bit slices
    assign add_a    = PW'(acc);
    assign add_b    = PW'(P);
    assign carry[0] = 1'b0;

    for (genvar gi = 0; gi < NST; gi++) begin : g_cla
        prod_acc_cla4 u_cla (
            .a    (add_a[4*gi +: 4]),
            .b    (add_b[4*gi +: 4]),
            .cin  (carry[gi]),
            .s    (add_s[4*gi +: 4]),
            .cout (carry[gi+1])
        );
    end

    // Carry out of bit ACC_W-1, wherever it lands in the padded result
    assign add_full = {carry[NST], add_s};
    assign add_cy   = add_full[ACC_W];

    assign Busy = (state != IDLE);

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        ovf_nx   = Overflow;
        sum_nx   = Sum;
        sv_nx    = Sum_valid;
        case (state)
            IDLE: begin
                if (Start) begin
                    cnt_nx   = (Len == 4'd0) ? 5'd16 : {1'b0, Len};
                    acc_nx   = '0;
                    ovf_nx   = 1'b0;
                    state_nx = ACCUM;
                end
            end
            ACCUM: begin
                if (P_valid) begin
                    acc_nx = add_s[ACC_W-1:0];
                    ovf_nx = Overflow | add_cy;
                    cnt_nx = cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state_nx = DONE;
                        sum_nx   = add_s[ACC_W-1:0];
                        sv_nx    = 1'b1;
                    end
                end
            end
            DONE: begin
                if (Res_ready) begin
                    state_nx = IDLE;
                    sv_nx    = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
                sv_nx    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            Sum       <= '0;
            Sum_valid <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            cnt       <= cnt_nx;
            Sum       <= sum_nx;
            Sum_valid <= sv_nx;
            Overflow  <= ovf_nx;
        end
    end

endmodule

// File: doc/prod_acc.md
PROD_ACC -- requirements
Module: prod_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 12: accumulator and Sum width in bits, legal range 8..16.
REQ-002 SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Start, input, 1 bit: begin a new accumulation run; sampled only in IDLE.
REQ-005 SHALL have port Len, input, 4 bits: products per run, sampled with Start; 0 means 16.
REQ-006 SHALL have port P_valid, input, 1 bit: P carries a valid 8-bit product this cycle.
REQ-007 SHALL have port P, input, 8 bits: unsigned product from the upstream multiplier stage.
REQ-008 SHALL have port Res_ready, input, 1 bit: downstream accepts Sum this cycle.
REQ-009 SHALL have port Busy, output, 1 bit: high in ACCUM and DONE.
REQ-010 SHALL have port Sum, output, ACC_W bits: accumulated total, valid while Sum_valid.
REQ-011 SHALL have port Sum_valid, output, 1 bit: high exactly in DONE.
REQ-012 SHALL have port Overflow, output, 1 bit: sticky carry-out of the accumulator for the current run.

Function
REQ-013 SHALL implement three states: IDLE, ACCUM, DONE, with one registered state variable.
REQ-014 IDLE: Start=1 SHALL load remaining count = (Len==0 ? 16 : Len), clear accumulator and Overflow, and enter ACCUM next cycle.
REQ-015 IDLE: P_valid SHALL be ignored, including when asserted in the same cycle as Start.
REQ-016 ACCUM: each cycle with P_valid=1 SHALL add zero-extended P to the accumulator and decrement the remaining count.
REQ-017 ACCUM: cycles with P_valid=0 SHALL hold all state unchanged (gaps allowed, no timeout).
REQ-018 ACCUM: the P_valid cycle that decrements the count from 1 to 0 SHALL enter DONE; Sum and Sum_valid are registered and appear the following cycle (latency 1 after the last product).
REQ-019 Addition SHALL be modulo 2^ACC_W; any carry out of bit ACC_W-1 SHALL set Overflow, which stays set until the next accepted Start.
REQ-020 DONE: Sum, Overflow SHALL hold stable while Sum_valid=1 and Res_ready=0.
REQ-021 DONE: Res_ready=1 SHALL return to IDLE next cycle with Sum_valid=0; Sum keeps its last value.
REQ-022 Start SHALL be ignored in ACCUM and DONE; P_valid SHALL be ignored in DONE.
REQ-023 Busy SHALL be combinationally derived from state only (no input-to-output paths).

Reset
REQ-024 Reset=0 SHALL asynchronously force state IDLE, accumulator 0, count 0, Sum 0, Sum_valid 0, Overflow 0, Busy 0.
REQ-025 Reset asserted mid-run SHALL abort the run with no Sum_valid pulse; release SHALL be synchronous to Clk and resume in IDLE.

Structure
REQ-026 State encodings (IDLE=2'b00, ACCUM=2'b01, DONE=2'b10) and the ACC_W default SHALL live in the shared package/header.
REQ-027 The accumulator adder SHALL be built from chained instances of the existing 4-bit CLA sub-module (ceil(ACC_W/4) stages, ripple carry between them); no other sub-module.
REQ-028 Control logic SHALL be one sequential block with asynchronous reset plus one combinational next-state block.

Verification
REQ-029 Len=3, P=10,20,30 on consecutive cycles -> one cycle after the third product Sum=60, Sum_valid=1, Overflow=0.
REQ-030 Len=0, sixteen products of 225 with random P_valid gaps -> Sum=3600, Overflow=0, Sum_valid only after the 16th.
REQ-031 ACC_W=8, Len=2, P=200,100 -> Sum=44, Overflow=1; next run Len=1, P=5 -> Sum=5, Overflow=0.
REQ-032 DONE with Res_ready=0 for 5 cycles, Start and P_valid pulsed -> Sum/Overflow unchanged, state stays DONE; Res_ready=1 -> IDLE next cycle.
REQ-033 Start=1 with P_valid=1, P=99 in IDLE, Len=1, then P=7 -> Sum=7 (the 99 is ignored).
REQ-034 Reset=0 asserted after 2 of 4 products -> all outputs 0 immediately, no Sum_valid; new run Len=1, P=8 -> Sum=8.
